// File: rtl/cronometro_velocista_if.sv
// Signal bundle between the race timer core and its environment:
// gate sensors and clear request in, binary M:SS:tt time and status flags out.
interface cronometro_velocista_if;
  logic       sensor_inicio;
  logic       sensor_fin;
  logic       btn_limpiar;
  logic [3:0] minutos_bin;
  logic [5:0] segundos_bin;
  logic [6:0] centesimas_bin;
  logic       corriendo;
  logic       finalizado;
  logic       desborde;

  modport master (
    output sensor_inicio,
    output sensor_fin,
    output btn_limpiar,
    input  minutos_bin,
    input  segundos_bin,
    input  centesimas_bin,
    input  corriendo,
    input  finalizado,
    input  desborde
  );

  modport slave (
    input  sensor_inicio,
    input  sensor_fin,
    input  btn_limpiar,
    output minutos_bin,
    output segundos_bin,
    output centesimas_bin,
    output corriendo,
    output finalizado,
    output desborde
  );
endinterface

// File: rtl/cronometro_velocista.sv
// Race timer core: synchronises start/finish gate sensors, runs the start/stop FSM and
// counts elapsed time in hundredths up to a saturating 9:59:99.
module cronometro_velocista #(
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned MIN_CENT = 50
) (
  input logic                   clk,
  input logic                   rst_n,
  cronometro_velocista_if.slave bus
);

  localparam logic [17:0] PrescMax = 18'(TICK_DIV - 1);
  localparam logic [6:0]  MinCent  = 7'(MIN_CENT);

  typedef enum logic [1:0] {
    StReposo    = 2'd0,
    StCorriendo = 2'd1,
    StDetenido  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [17:0] presc_q, presc_d;
  logic [3:0]  min_q, min_d;
  logic [5:0]  seg_q, seg_d;
  logic [6:0]  cen_q, cen_d;
  logic        desb_q, desb_d;
  logic        corr_q, corr_d;
  logic        fin_q, fin_d;

  logic [1:0]  ini_sync_q, fin_sync_q;
  logic        ini_prev_q, fin_prev_q;
  logic        ini_edge, fin_edge;
  logic        tick, elapsed_ok, at_max;

  // Two-flop synchronisers followed by a previous-value register for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ini_sync_q <= 2'b00;
      fin_sync_q <= 2'b00;
      ini_prev_q <= 1'b0;
      fin_prev_q <= 1'b0;
    end else begin
      ini_sync_q <= {ini_sync_q[0], bus.sensor_inicio};
      fin_sync_q <= {fin_sync_q[0], bus.sensor_fin};
      ini_prev_q <= ini_sync_q[1];
      fin_prev_q <= fin_sync_q[1];
    end
  end

  assign ini_edge = ini_sync_q[1] & ~ini_prev_q;
  assign fin_edge = fin_sync_q[1] & ~fin_prev_q;

  assign tick       = (state_q == StCorriendo) && (presc_q == PrescMax);
  assign elapsed_ok = (min_q != 4'd0) || (seg_q != 6'd0) || (cen_q >= MinCent);
  assign at_max     = (min_q == 4'd9) && (seg_q == 6'd59) && (cen_q == 7'd99);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    min_d   = min_q;
    seg_d   = seg_q;
    cen_d   = cen_q;
    desb_d  = desb_q;

    if (bus.btn_limpiar) begin
      state_d = StReposo;
      presc_d = 18'd0;
      min_d   = 4'd0;
      seg_d   = 6'd0;
      cen_d   = 7'd0;
      desb_d  = 1'b0;
    end else begin
      unique case (state_q)
        StReposo: begin
          // Simultaneous finish edge is simply not looked at here.
          if (ini_edge) begin
            state_d = StCorriendo;
            presc_d = 18'd0;
          end
        end
        StCorriendo: begin
          if (fin_edge && elapsed_ok) begin
            // Finish beats a coincident tick: time shown is the value before this edge.
            state_d = StDetenido;
          end else begin
            presc_d = tick ? 18'd0 : presc_q + 18'd1;
            if (tick) begin
              if (at_max) begin
                desb_d  = 1'b1;
                state_d = StDetenido;
              end else if (cen_q != 7'd99) begin
                cen_d = cen_q + 7'd1;
              end else begin
                cen_d = 7'd0;
                if (seg_q != 6'd59) begin
                  seg_d = seg_q + 6'd1;
                end else begin
                  seg_d = 6'd0;
                  min_d = min_q + 4'd1;
                end
              end
            end
          end
        end
        StDetenido: begin
          state_d = StDetenido;
        end
        default: begin
          state_d = StReposo;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so outputs come straight from flops.
  assign corr_d = (state_d == StCorriendo);
  assign fin_d  = (state_d == StDetenido);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReposo;
      presc_q <= 18'd0;
      min_q   <= 4'd0;
      seg_q   <= 6'd0;
      cen_q   <= 7'd0;
      desb_q  <= 1'b0;
      corr_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      min_q   <= min_d;
      seg_q   <= seg_d;
      cen_q   <= cen_d;
      desb_q  <= desb_d;
      corr_q  <= corr_d;
      fin_q   <= fin_d;
    end
  end

  assign bus.minutos_bin    = min_q;
  assign bus.segundos_bin   = seg_q;
  assign bus.centesimas_bin = cen_q;
  assign bus.corriendo      = corr_q;
  assign bus.finalizado     = fin_q;
  assign bus.desborde       = desb_q;

  a_cen_range: assert property (@(posedge clk) disable iff (!rst_n) cen_q <= 7'd99);
  a_seg_range: assert property (@(posedge clk) disable iff (!rst_n) seg_q <= 6'd59);
  a_min_range: assert property (@(posedge clk) disable iff (!rst_n) min_q <= 4'd9);
  a_flags_excl: assert property (@(posedge clk) disable iff (!rst_n) !(corr_q && fin_q));
  a_desb_stop: assert property (@(posedge clk) disable iff (!rst_n) desb_q |-> fin_q);

endmodule

// File: tb/tb_cronometro_velocista.sv
// Directed bench for cronometro_velocista: one DUT with TICK_DIV=10 for timing/FSM
// scenarios, one with TICK_DIV=1 so saturation at 9:59:99 is reachable quickly.
module tb_cronometro_velocista;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  cronometro_velocista_if bus_a ();
  cronometro_velocista_if bus_b ();

  cronometro_velocista #(
    .TICK_DIV (10),
    .MIN_CENT (50)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  cronometro_velocista #(
    .TICK_DIV (1),
    .MIN_CENT (50)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {minutos, segundos, centesimas, corriendo, finalizado, desborde}.
  function automatic logic [19:0] snap_a();
    return {bus_a.minutos_bin, bus_a.segundos_bin, bus_a.centesimas_bin,
            bus_a.corriendo, bus_a.finalizado, bus_a.desborde};
  endfunction

  function automatic logic [19:0] snap_b();
    return {bus_b.minutos_bin, bus_b.segundos_bin, bus_b.centesimas_bin,
            bus_b.corriendo, bus_b.finalizado, bus_b.desborde};
  endfunction

  function automatic logic [19:0] ev(int m, int s, int c, logic [2:0] f);
    return {4'(m), 6'(s), 7'(c), f};
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start pulse on DUT A; returns one time unit after the edge where the state changes.
  task automatic start_a();
    bus_a.sensor_inicio = 1'b1;
    cyc(1);
    bus_a.sensor_inicio = 1'b0;
    cyc(2);
  endtask

  task automatic clear_a();
    bus_a.btn_limpiar = 1'b1;
    cyc(1);
    bus_a.btn_limpiar = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got;
    rst_n = 1'b0;
    #3;
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b000)) begin
      n_bad++;
      $display("FAIL reset_a: got %h want %h", got, ev(0, 0, 0, 3'b000));
    end
    got = snap_b();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b000)) begin
      n_bad++;
      $display("FAIL reset_b: got %h want %h", got, ev(0, 0, 0, 3'b000));
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b000)) begin
      n_bad++;
      $display("FAIL idle_a: got %h want %h", got, ev(0, 0, 0, 3'b000));
    end
  endtask

  task automatic test_start_timing();
    logic [19:0] got;
    bus_a.sensor_inicio = 1'b1;
    cyc(1);
    bus_a.sensor_inicio = 1'b0;
    cyc(1);
    n_cmp++;
    if (bus_a.corriendo !== 1'b0) begin
      n_bad++;
      $display("FAIL start_latency_early: got corriendo=%b want 0", bus_a.corriendo);
    end
    cyc(1);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b100)) begin
      n_bad++;
      $display("FAIL start_edge: got %h want %h", got, ev(0, 0, 0, 3'b100));
    end
    cyc(9);
    n_cmp++;
    if (bus_a.centesimas_bin !== 7'd0) begin
      n_bad++;
      $display("FAIL first_tick_early: got cen=%0d want 0", bus_a.centesimas_bin);
    end
    cyc(1);
    n_cmp++;
    if (bus_a.centesimas_bin !== 7'd1) begin
      n_bad++;
      $display("FAIL first_tick: got cen=%0d want 1", bus_a.centesimas_bin);
    end
    cyc(989);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 99, 3'b100)) begin
      n_bad++;
      $display("FAIL run_0_99: got %h want %h", got, ev(0, 0, 99, 3'b100));
    end
    cyc(1);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 1, 0, 3'b100)) begin
      n_bad++;
      $display("FAIL run_1_00: got %h want %h", got, ev(0, 1, 0, 3'b100));
    end
  endtask

  task automatic test_min_cent();
    logic [19:0] got;
    clear_a();
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b000)) begin
      n_bad++;
      $display("FAIL clear_running: got %h want %h", got, ev(0, 0, 0, 3'b000));
    end
    start_a();
    cyc(200);
    // Finish edge lands at elapsed 0:00:20, below MIN_CENT.
    bus_a.sensor_fin = 1'b1;
    cyc(1);
    bus_a.sensor_fin = 1'b0;
    cyc(9);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 21, 3'b100)) begin
      n_bad++;
      $display("FAIL early_finish_ignored: got %h want %h", got, ev(0, 0, 21, 3'b100));
    end
    cyc(2158);
    bus_a.sensor_fin = 1'b1;
    cyc(1);
    bus_a.sensor_fin = 1'b0;
    cyc(1);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 2, 37, 3'b100)) begin
      n_bad++;
      $display("FAIL finish_latency: got %h want %h", got, ev(0, 2, 37, 3'b100));
    end
    cyc(1);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 2, 37, 3'b010)) begin
      n_bad++;
      $display("FAIL finish_stop: got %h want %h", got, ev(0, 2, 37, 3'b010));
    end
    cyc(100);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 2, 37, 3'b010)) begin
      n_bad++;
      $display("FAIL frozen: got %h want %h", got, ev(0, 2, 37, 3'b010));
    end
    bus_a.sensor_inicio = 1'b1;
    bus_a.sensor_fin    = 1'b1;
    cyc(1);
    bus_a.sensor_inicio = 1'b0;
    bus_a.sensor_fin    = 1'b0;
    cyc(20);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 2, 37, 3'b010)) begin
      n_bad++;
      $display("FAIL pulses_in_stop: got %h want %h", got, ev(0, 2, 37, 3'b010));
    end
  endtask

  task automatic test_tick_coincide();
    logic [19:0] got;
    clear_a();
    start_a();
    // Finish edge is timed to act on the same clk edge as the 0:02:99 -> 0:03:00 tick.
    cyc(2997);
    bus_a.sensor_fin = 1'b1;
    cyc(1);
    bus_a.sensor_fin = 1'b0;
    cyc(1);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 2, 99, 3'b100)) begin
      n_bad++;
      $display("FAIL pre_coincide: got %h want %h", got, ev(0, 2, 99, 3'b100));
    end
    cyc(1);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 2, 99, 3'b010)) begin
      n_bad++;
      $display("FAIL coincide_finish_wins: got %h want %h", got, ev(0, 2, 99, 3'b010));
    end
  endtask

  task automatic test_clear_priority_a();
    logic [19:0] got;
    bus_a.sensor_inicio = 1'b1;
    cyc(1);
    bus_a.sensor_inicio = 1'b0;
    cyc(1);
    bus_a.btn_limpiar = 1'b1;
    cyc(1);
    bus_a.btn_limpiar = 1'b0;
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b000)) begin
      n_bad++;
      $display("FAIL clear_vs_start_a: got %h want %h", got, ev(0, 0, 0, 3'b000));
    end
    cyc(20);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b000)) begin
      n_bad++;
      $display("FAIL start_not_kept_a: got %h want %h", got, ev(0, 0, 0, 3'b000));
    end
  endtask

  task automatic test_async_reset();
    logic [19:0] got;
    start_a();
    cyc(50);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 5, 3'b100)) begin
      n_bad++;
      $display("FAIL run_before_reset: got %h want %h", got, ev(0, 0, 5, 3'b100));
    end
    rst_n = 1'b0;
    #2;
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b000)) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", got, ev(0, 0, 0, 3'b000));
    end
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    // Held-high start sensor: one edge only, so a clear while held leaves it idle.
    bus_a.sensor_inicio = 1'b1;
    cyc(3);
    n_cmp++;
    if (bus_a.corriendo !== 1'b1) begin
      n_bad++;
      $display("FAIL held_start_runs: got corriendo=%b want 1", bus_a.corriendo);
    end
    clear_a();
    cyc(20);
    got = snap_a();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b000)) begin
      n_bad++;
      $display("FAIL held_single_edge: got %h want %h", got, ev(0, 0, 0, 3'b000));
    end
    bus_a.sensor_inicio = 1'b0;
    cyc(5);
  endtask

  task automatic test_saturation();
    logic [19:0] got;
    bus_b.sensor_inicio = 1'b1;
    cyc(1);
    bus_b.sensor_inicio = 1'b0;
    cyc(2);
    cyc(59998);
    got = snap_b();
    n_cmp++;
    if (got !== ev(9, 59, 98, 3'b100)) begin
      n_bad++;
      $display("FAIL sat_9_59_98: got %h want %h", got, ev(9, 59, 98, 3'b100));
    end
    cyc(1);
    got = snap_b();
    n_cmp++;
    if (got !== ev(9, 59, 99, 3'b100)) begin
      n_bad++;
      $display("FAIL sat_9_59_99: got %h want %h", got, ev(9, 59, 99, 3'b100));
    end
    cyc(1);
    got = snap_b();
    n_cmp++;
    if (got !== ev(9, 59, 99, 3'b011)) begin
      n_bad++;
      $display("FAIL sat_desborde: got %h want %h", got, ev(9, 59, 99, 3'b011));
    end
    cyc(10);
    got = snap_b();
    n_cmp++;
    if (got !== ev(9, 59, 99, 3'b011)) begin
      n_bad++;
      $display("FAIL sat_hold: got %h want %h", got, ev(9, 59, 99, 3'b011));
    end
  endtask

  task automatic test_clear_priority_b();
    logic [19:0] got;
    bus_b.sensor_inicio = 1'b1;
    cyc(1);
    bus_b.sensor_inicio = 1'b0;
    cyc(1);
    bus_b.btn_limpiar = 1'b1;
    cyc(1);
    bus_b.btn_limpiar = 1'b0;
    got = snap_b();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b000)) begin
      n_bad++;
      $display("FAIL clear_vs_start_b: got %h want %h", got, ev(0, 0, 0, 3'b000));
    end
    cyc(10);
    got = snap_b();
    n_cmp++;
    if (got !== ev(0, 0, 0, 3'b000)) begin
      n_bad++;
      $display("FAIL start_not_kept_b: got %h want %h", got, ev(0, 0, 0, 3'b000));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus_a.sensor_inicio = 1'b0;
    bus_a.sensor_fin    = 1'b0;
    bus_a.btn_limpiar   = 1'b0;
    bus_b.sensor_inicio = 1'b0;
    bus_b.sensor_fin    = 1'b0;
    bus_b.btn_limpiar   = 1'b0;
    rst_n = 1'b0;

    test_reset();
    test_start_timing();
    test_min_cent();
    test_tick_coincide();
    test_clear_priority_a();
    test_async_reset();
    test_saturation();
    test_clear_priority_b();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cronometro_velocista.md
Name: cronometro_velocista

Overview:
- Race timer core for the line-follower stopwatch; directly upstream of the 5-digit display controller.
- Synchronises the start-gate and finish-gate sensors and runs a start/stop state machine.
- Counts elapsed time at 0.01 s resolution from the 25 MHz system clock.
- Presents M:SS:tt as binary fields (minutes 0-9, seconds 0-59, hundredths 0-99), plus status flags.

Parameters:
- TICK_DIV, 250000, clk cycles per hundredth of a second (25 MHz / 100 Hz).
- MIN_CENT, 50, minimum elapsed hundredths before a finish edge is accepted; legal range 1-99.

Ports:
- clk  input  1  system clock, 25 MHz; the only clock in the block.
- rst_n  input  1  asynchronous, active-low reset.
- sensor_inicio  input  1  start-gate sensor, asynchronous, active-high (beam broken = 1).
- sensor_fin  input  1  finish-gate sensor, asynchronous, active-high.
- btn_limpiar  input  1  clear request, already debounced, synchronous to clk, active-high level.
- minutos_bin  output  4  elapsed minutes, 0-9.
- segundos_bin  output  6  elapsed seconds, 0-59.
- centesimas_bin  output  7  elapsed hundredths, 0-99.
- corriendo  output  1  1 while in state CORRIENDO.
- finalizado  output  1  1 while in state DETENIDO.
- desborde  output  1  1 when the count saturated at 9:59:99.

Behaviour:
- Clock and reset:
  - One clock (clk); reset rst_n is asynchronous, active-low.
  - All flops clear on reset: state=REPOSO, all counters 0, all outputs 0, synchroniser flops 0.
- Input synchronisation and edge detection:
  - Each sensor passes through a 2-flop synchroniser, then a previous-value register.
  - An edge is the cycle where sync=1 and prev=0.
  - Only rising edges act; levels are ignored.
  - A held-high sensor produces exactly one edge.
- State machine (REPOSO, CORRIENDO, DETENIDO):
  - REPOSO -> CORRIENDO on a start edge. Counters are already 0. The prescaler loads 0 on the same clk edge the state changes.
  - CORRIENDO -> DETENIDO on a finish edge, when elapsed >= MIN_CENT. Elapsed >= MIN_CENT means minutos>0, or segundos>0, or centesimas>=MIN_CENT.
  - CORRIENDO: a finish edge with elapsed < MIN_CENT is discarded; it is not remembered.
  - CORRIENDO -> DETENIDO on saturation (see below).
  - Any state -> REPOSO with all counters and desborde cleared, in every cycle where btn_limpiar=1.
  - btn_limpiar has priority over every other event.
  - Start edges in CORRIENDO or DETENIDO are ignored. Finish edges in REPOSO or DETENIDO are ignored.
  - Simultaneous start and finish edges in REPOSO: start is taken, finish is discarded.
- Prescaler:
  - 18-bit counter; advances only in CORRIENDO; wraps at TICK_DIV-1.
  - Tick is asserted in the cycle it equals TICK_DIV-1.
  - The first hundredth increments exactly TICK_DIV cycles after the state becomes CORRIENDO.
  - Holds its value in REPOSO and DETENIDO.
- Time counters (update on tick):
  - centesimas increments. At 99 it wraps to 0 and segundos increments.
  - segundos at 59 wraps to 0 and minutos increments.
  - No field ever exceeds its maximum.
- Saturation:
  - A tick at 9:59:99 leaves the counters at 9:59:99.
  - On that tick, desborde goes to 1 and the state goes to DETENIDO.
- Finish and tick in the same cycle:
  - The finish wins and the tick is not applied.
  - The displayed time is the value held before that edge.
- Outputs:
  - Driven directly from registers, with no combinational path from the inputs.
  - Latency from a sensor pin rising to the state/flag change is 3 clk edges: 2 synchroniser flops plus the state register.
  - Counters are frozen in DETENIDO until a clear.
- Reset mid-run: rst_n low at any time returns everything to REPOSO/0 immediately, with no clk required.

Test Plan:
- Reset with rst_n=0, then release; no sensor activity -> all outputs 0, state REPOSO, counters stay 0:00:00.
- Start pulse, then wait 100*TICK_DIV cycles (use TICK_DIV=10 in simulation) -> outputs 0:01:00, corriendo=1. Also check exact timing: centesimas=1 exactly TICK_DIV cycles after corriendo rises.
- Run with MIN_CENT=50:
  - Finish pulse at elapsed 0:00:20 -> ignored, count continues.
  - Finish pulse at 0:02:37 -> frozen at 0:02:37, finalizado=1, corriendo=0.
  - Further start and finish pulses -> no change.
- Preload or run to 9:59:98, then two ticks -> 9:59:99, desborde=1, finalizado=1, no wrap to 0.
- btn_limpiar asserted in the same cycle as a start edge while in DETENIDO -> REPOSO, 0:00:00, desborde=0, start ignored.
- Finish edge coincident with the tick that would give 0:03:00 from 0:02:99 -> frozen at 0:02:99. Separately, rst_n pulsed low mid-run -> asynchronous clear to 0 without clk.
